// File: rtl/tlb_page_walker.sv
// Radix page-table walker for TLB misses: one walk at a time, one PTE read per level,
// ending in a one-cycle fill pulse or a fault pulse.
module tlb_page_walker #(
   parameter int ADDR   = 64,
   parameter int PAGE   = 12,
   parameter int PCID   = 12,
   parameter int LEVELS = 4,
   parameter int IDX_B  = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            miss_valid,
   output logic            miss_ready,
   input  logic [ADDR-1:0] miss_va,
   input  logic [PCID-1:0] miss_pcid,
   input  logic [ADDR-1:0] root_base,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [ADDR-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [63:0]     mem_rsp_data,
   output logic            fill_valid,
   output logic [ADDR-1:0] fill_va,
   output logic [PCID-1:0] fill_pcid,
   output logic [ADDR-1:0] fill_pa,
   output logic            fault
);

   localparam int VA_TOP = PAGE + LEVELS * IDX_B;
   localparam int VPN_W  = ADDR - PAGE;
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT} state_t;

   state_t           state_q, state_d;
   logic [LVL_W-1:0] lvl_q;
   logic [VPN_W-1:0] vpn_q;
   logic [PCID-1:0]  pcid_q;
   logic [ADDR-1:0]  base_q;
   logic             canonical;
   logic [IDX_B-1:0] pte_idx;
   logic [ADDR-1:0]  req_addr;
   logic             unused_bits;

   assign unused_bits = ^{mem_rsp_data[PAGE-1:1], miss_va[PAGE-1:0]};

   // Bits above the translated range must be a sign-extension of the top translated bit.
   always_comb begin
      canonical = 1'b1;
      for (int i = VA_TOP; i < ADDR; i++) begin
         if (miss_va[i] != miss_va[VA_TOP-1]) canonical = 1'b0;
      end
   end

   assign pte_idx  = vpn_q[IDX_B*int'(lvl_q) +: IDX_B];
   assign req_addr = base_q + (ADDR'(pte_idx) << 3);

   always_comb begin
      state_d       = state_q;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      fill_valid    = 1'b0;
      fault         = 1'b0;
      case (state_q)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) state_d = canonical ? REQ : FAULT;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = req_addr;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               if (!mem_rsp_data[0])  state_d = FAULT;
               else if (lvl_q == '0)  state_d = FILL;
               else                   state_d = REQ;
            end
         end
         FILL: begin
            fill_valid = 1'b1;
            state_d    = IDLE;
         end
         FAULT: begin
            fault   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The fill_* registers are only loaded on entry to FILL/FAULT so they hold between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lvl_q     <= '0;
         vpn_q     <= '0;
         pcid_q    <= '0;
         base_q    <= '0;
         fill_va   <= '0;
         fill_pcid <= '0;
         fill_pa   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && miss_valid) begin
            vpn_q  <= miss_va[ADDR-1:PAGE];
            pcid_q <= miss_pcid;
            base_q <= root_base;
            lvl_q  <= LVL_W'(LEVELS - 1);
         end
         if (state_q == WAIT && mem_rsp_valid && mem_rsp_data[0] && lvl_q != '0) begin
            base_q <= {mem_rsp_data[ADDR-1:PAGE], {PAGE{1'b0}}};
            lvl_q  <= lvl_q - 1'b1;
         end
         if (state_d == FAULT) begin
            fill_va   <= {(state_q == IDLE) ? miss_va[ADDR-1:PAGE] : vpn_q, {PAGE{1'b0}}};
            fill_pcid <= (state_q == IDLE) ? miss_pcid : pcid_q;
            fill_pa   <= '0;
         end
         if (state_d == FILL) begin
            fill_va   <= {vpn_q, {PAGE{1'b0}}};
            fill_pcid <= pcid_q;
            fill_pa   <= {mem_rsp_data[ADDR-1:PAGE], {PAGE{1'b0}}};
         end
      end
   end

endmodule

// File: tb/tb_tlb_page_walker.sv
// Scoreboard bench for tlb_page_walker: directed walks push expected requests and
// fill/fault events; a negedge monitor pops and compares whatever the DUT presents.
module tb_tlb_page_walker;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [63:0] miss_va;
   logic [11:0] miss_pcid;
   logic [63:0] root_base;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic        fill_valid;
   logic [63:0] fill_va;
   logic [11:0] fill_pcid;
   logic [63:0] fill_pa;
   logic        fault;

   typedef struct {
      bit          isFault;
      logic [63:0] va;
      logic [11:0] pcid;
      logic [63:0] pa;
      int          latency;
   } event_t;

   logic [63:0] expReq[$];
   event_t      expEvt[$];
   logic [63:0] pteMem [logic [63:0]];

   int          compared = 0;
   int          mismatched = 0;
   int          sampleCnt = 0;
   int          acceptCount = 0;
   int          acceptSample = 0;
   int          lastEventSample = 0;
   int          eventCount = 0;
   int          reqCount = 0;
   int          gapCheckAccept = -1;
   bit          walkBusy = 1'b0;
   bit          stallSeen = 1'b0;
   logic [63:0] stallAddrSeen = '0;
   logic [63:0] stallAddr = '1;
   int          stallBudget = 0;
   int          stallUsed = 0;
   bit          injectRsp = 1'b0;

   tlb_page_walker dut (
      .clk           (clk),
      .rst           (rst),
      .miss_valid    (miss_valid),
      .miss_ready    (miss_ready),
      .miss_va       (miss_va),
      .miss_pcid     (miss_pcid),
      .root_base     (root_base),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .fill_valid    (fill_valid),
      .fill_va       (fill_va),
      .fill_pcid     (fill_pcid),
      .fill_pa       (fill_pa),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endfunction

   function automatic void expectEvent(bit isFault, logic [63:0] va, logic [11:0] pcid,
                                       logic [63:0] pa, int latency);
      event_t e;
      e.isFault = isFault;
      e.va      = va;
      e.pcid    = pcid;
      e.pa      = pa;
      e.latency = latency;
      expEvt.push_back(e);
   endfunction

   function automatic void expectHitReqs(logic [63:0] lastAddr);
      expReq.push_back(64'h1000);
      expReq.push_back(64'h2000);
      expReq.push_back(64'h3010);
      expReq.push_back(lastAddr);
   endfunction

   // Memory model: responds one cycle after each accepted request, optional stall on one address.
   initial begin
      logic        taken;
      logic [63:0] takenAddr;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         taken     = !rst && mem_req_valid && mem_req_ready;
         takenAddr = mem_req_addr;
         @(posedge clk);
         #1;
         mem_rsp_valid = 1'b0;
         mem_req_ready = 1'b1;
         if (!rst) begin
            if (taken) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = pteMem.exists(takenAddr) ? pteMem[takenAddr] : 64'h0;
            end else if (injectRsp) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = 64'h4001;
            end
            if (mem_req_valid && mem_req_addr == stallAddr && stallUsed < stallBudget) begin
               mem_req_ready = 1'b0;
               stallUsed++;
            end
         end
      end
   end

   // Monitor: checks requests, backpressure stability, busy-ness and fill/fault events.
   always @(negedge clk) begin : monitor
      event_t e;
      sampleCnt++;
      if (rst) begin
         walkBusy  = 1'b0;
         stallSeen = 1'b0;
      end else begin
         if (walkBusy) checkOutput("miss_ready_busy", miss_ready, 0);
         if (miss_valid && miss_ready) begin
            acceptCount++;
            if (acceptCount == gapCheckAccept)
               checkOutput("accept_gap", sampleCnt - lastEventSample, 1);
            acceptSample = sampleCnt;
            walkBusy     = 1'b1;
         end
         if (stallSeen) begin
            checkOutput("stall_valid", mem_req_valid, 1);
            checkOutput("stall_addr", mem_req_addr, stallAddrSeen);
         end
         stallSeen     = mem_req_valid && !mem_req_ready;
         stallAddrSeen = mem_req_addr;
         if (mem_req_valid && mem_req_ready) begin
            reqCount++;
            checkOutput("req_expected", expReq.size() > 0, 1);
            if (expReq.size() > 0) checkOutput("req_addr", mem_req_addr, expReq.pop_front());
         end
         if (fill_valid || fault) begin
            eventCount++;
            lastEventSample = sampleCnt;
            walkBusy        = 1'b0;
            checkOutput("fill_and_fault", fill_valid && fault, 0);
            checkOutput("event_expected", expEvt.size() > 0, 1);
            if (expEvt.size() > 0) begin
               e = expEvt.pop_front();
               checkOutput("event_kind", fault, e.isFault);
               checkOutput("fill_va", fill_va, e.va);
               checkOutput("fill_pcid", fill_pcid, e.pcid);
               checkOutput("fill_pa", fill_pa, e.pa);
               checkOutput("latency", sampleCnt - acceptSample, e.latency);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [63:0] va, input logic [11:0] pcid,
                                input logic [63:0] root, input bit holdValid);
      int n;
      n          = 0;
      miss_va    = va;
      miss_pcid  = pcid;
      root_base  = root;
      miss_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!miss_ready && n < 50);
      if (!miss_ready) checkOutput("miss_accept_timeout", miss_ready, 1);
      @(posedge clk);
      #1;
      if (!holdValid) miss_valid = 1'b0;
   endtask

   task automatic waitEvents(input int target);
      int n;
      n = 0;
      while (eventCount < target && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("event_count", eventCount, target);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_miss_ready"}, miss_ready, 1);
      checkOutput({tag, "_mem_req_valid"}, mem_req_valid, 0);
      checkOutput({tag, "_mem_req_addr"}, mem_req_addr, 0);
      checkOutput({tag, "_fill_valid"}, fill_valid, 0);
      checkOutput({tag, "_fault"}, fault, 0);
      checkOutput({tag, "_fill_va"}, fill_va, 0);
      checkOutput({tag, "_fill_pcid"}, fill_pcid, 0);
      checkOutput({tag, "_fill_pa"}, fill_pa, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int base;
      rst        = 1'b1;
      miss_valid = 1'b0;
      miss_va    = '0;
      miss_pcid  = '0;
      root_base  = '0;
      pteMem[64'h1000] = 64'h2001;
      pteMem[64'h2000] = 64'h3001;
      pteMem[64'h3010] = 64'h4001;
      pteMem[64'h4018] = 64'h0ABCD001;
      pteMem[64'h4028] = 64'h0DEF0001;

      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] full 4-level hit");
      expectHitReqs(64'h4018);
      expectEvent(1'b0, 64'h403000, 12'h5, 64'h0ABCD000, 9);
      applyStimulus(64'h0000_0000_0040_3123, 12'h5, 64'h1000, 1'b0);
      waitEvents(1);
      checkOutput("fill_hold_pa", fill_pa, 64'h0ABCD000);
      checkOutput("fill_hold_valid", fill_valid, 0);

      $display("[TB] not present at level 2");
      pteMem[64'h2000] = 64'h3000;
      expReq.push_back(64'h1000);
      expReq.push_back(64'h2000);
      expectEvent(1'b1, 64'h403000, 12'h5, 64'h0, 5);
      applyStimulus(64'h0000_0000_0040_3123, 12'h5, 64'h1000, 1'b0);
      waitEvents(2);
      pteMem[64'h2000] = 64'h3001;

      $display("[TB] non-canonical VA");
      expectEvent(1'b1, 64'h0001_0000_0000_0000, 12'h7, 64'h0, 1);
      applyStimulus(64'h0001_0000_0000_0000, 12'h7, 64'h1000, 1'b0);
      waitEvents(3);

      $display("[TB] backpressure on level-1 request");
      stallAddr   = 64'h3010;
      stallBudget = stallUsed + 5;
      expectHitReqs(64'h4018);
      expectEvent(1'b0, 64'h403000, 12'hABC, 64'h0ABCD000, 14);
      applyStimulus(64'h0000_0000_0040_3123, 12'hABC, 64'h1000, 1'b0);
      waitEvents(4);
      checkOutput("stall_cycles_used", stallUsed, stallBudget);
      stallAddr = '1;

      $display("[TB] reset mid-walk");
      base = reqCount;
      expReq.push_back(64'h1000);
      expReq.push_back(64'h2000);
      expReq.push_back(64'h3010);
      applyStimulus(64'h0000_0000_0040_3123, 12'h9, 64'h1000, 1'b0);
      n = 0;
      while (reqCount < base + 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checkOutput("reset_walk_reqs", reqCount, base + 3);
      #2;
      rst = 1'b1;
      #1;
      checkResetOutputs("midreset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      injectRsp = 1'b1;
      @(negedge clk);
      injectRsp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("after_late_rsp_events", eventCount, 4);
      checkOutput("after_late_rsp_ready", miss_ready, 1);
      expectHitReqs(64'h4018);
      expectEvent(1'b0, 64'h403000, 12'h9, 64'h0ABCD000, 9);
      applyStimulus(64'h0000_0000_0040_3123, 12'h9, 64'h1000, 1'b0);
      waitEvents(5);

      $display("[TB] back-to-back misses");
      base           = acceptCount;
      gapCheckAccept = base + 2;
      expectHitReqs(64'h4018);
      expectHitReqs(64'h4028);
      expectEvent(1'b0, 64'h403000, 12'h1, 64'h0ABCD000, 9);
      expectEvent(1'b0, 64'h405000, 12'h2, 64'h0DEF0000, 9);
      applyStimulus(64'h0000_0000_0040_3123, 12'h1, 64'h1000, 1'b1);
      miss_va   = 64'h0000_0000_0040_5456;
      miss_pcid = 12'h2;
      n = 0;
      while (acceptCount < base + 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      miss_valid = 1'b0;
      checkOutput("b2b_accepts", acceptCount, base + 2);
      waitEvents(7);

      checkOutput("req_queue_left", expReq.size(), 0);
      checkOutput("evt_queue_left", expEvt.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
